// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state encoding and width defaults for pwm_capture
package pwm_capture_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// rtl/pwm_in_sync.sv - pwm_in synchroniser with rise/fall edge detection
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  // SYNC_STAGES must be at least 2 so the first flop can settle metastability
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // Shift the pin through the chain and keep one cycle of history of the last stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      level_d <= level;
    end
  end

  // Edges are combinational so the FSM acts on them at the very next clock
  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an external PWM in prescaled ticks
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic [DIV_W-1:0] div,
  output logic [CNT_W-1:0] high_ticks,
  output logic [CNT_W-1:0] period_ticks,
  output logic             meas_valid,
  output logic             stalled,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             rise;
  logic             fall;
  logic             tick;
  logic             rearm;
  logic [DIV_W-1:0] presc_cnt;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_high;
  logic [CNT_W-1:0] cnt_per;
  logic [CNT_W-1:0] h_shadow;
  state_t           state;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .pwm_in(pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign tick  = (div != '0) && (presc_cnt >= div - DIV_W'(1));
  // A zero or freshly changed divider invalidates any in-flight measurement
  assign rearm = (div == '0) || (div != div_q);

  // Free-running prescaler plus a registered copy of div for change detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
      div_q     <= '0;
    end else begin
      div_q <= div;
      if ((div == '0) || tick) presc_cnt <= '0;
      else                     presc_cnt <= presc_cnt + DIV_W'(1);
    end
  end

  // Measurement FSM: counts ticks between edges and publishes results on each rise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt_high     <= '0;
      cnt_per      <= '0;
      h_shadow     <= '0;
      high_ticks   <= '0;
      period_ticks <= '0;
      meas_valid   <= 1'b0;
      stalled      <= 1'b0;
      locked       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rearm) begin
        state    <= IDLE;
        cnt_high <= '0;
        cnt_per  <= '0;
        h_shadow <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              cnt_high <= CNT_W'(tick);
              cnt_per  <= CNT_W'(tick);
              state    <= HIGH;
            end
          end
          HIGH: begin
            if (cnt_per == CNT_MAX) begin
              stalled <= 1'b1;
              state   <= IDLE;
            end else if (fall) begin
              h_shadow <= cnt_high;
              cnt_per  <= cnt_per + CNT_W'(tick);
              state    <= LOW;
            end else if (tick) begin
              if (cnt_high != CNT_MAX) cnt_high <= cnt_high + CNT_W'(1);
              cnt_per <= cnt_per + CNT_W'(1);
            end
          end
          LOW: begin
            if (cnt_per == CNT_MAX) begin
              stalled <= 1'b1;
              state   <= IDLE;
            end else if (rise) begin
              period_ticks <= cnt_per;
              high_ticks   <= h_shadow;
              meas_valid   <= 1'b1;
              locked       <= 1'b1;
              stalled      <= 1'b0;
              cnt_high     <= CNT_W'(tick);
              cnt_per      <= CNT_W'(tick);
              state        <= HIGH;
            end else if (tick) begin
              cnt_per <= cnt_per + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized self-checking bench for pwm_capture
module tb_pwm_capture;

  localparam int CNT_W = 16;
  localparam int DIV_W = 8;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;

  logic             clock  = 1'b0;
  logic             reset  = 1'b1;
  logic             pwm_in = 1'b0;
  logic [DIV_W-1:0] div    = '0;
  logic [CNT_W-1:0] high_ticks;
  logic [CNT_W-1:0] period_ticks;
  logic             meas_valid;
  logic             stalled;
  logic             locked;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pulse = 0;
  int exp_high = 0;
  int exp_per  = 0;
  int rise_q[$];

  pwm_capture #(
    .CNT_W(CNT_W),
    .DIV_W(DIV_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .div         (div),
    .high_ticks  (high_ticks),
    .period_ticks(period_ticks),
    .meas_valid  (meas_valid),
    .stalled     (stalled),
    .locked      (locked)
  );

  always #5 clock = ~clock;

  // Cycle index used to time pulses against the rises that caused them
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor: every pulse carries the expected ticks, arrives LAT cycles after its rise,
  // and results never move without a pulse
  initial begin : monitor
    logic             prev_pwm;
    logic             prev_mv;
    logic [CNT_W-1:0] prev_h;
    logic [CNT_W-1:0] prev_p;
    prev_pwm = 1'b0;
    prev_mv  = 1'b0;
    prev_h   = '0;
    prev_p   = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        rise_q.delete();
      end else begin
        if (pwm_in && !prev_pwm) rise_q.push_back(cyc);
        if (meas_valid) begin
          n_pulse++;
          check("high_ticks", high_ticks, exp_high);
          check("period_ticks", period_ticks, exp_per);
          while (rise_q.size() > 0 && rise_q[0] < cyc - LAT) void'(rise_q.pop_front());
          check("latency", (rise_q.size() > 0) ? cyc - rise_q[0] : -1, LAT);
          if (prev_mv) check("mv_back_to_back", 1, 0);
        end else if (high_ticks !== prev_h || period_ticks !== prev_p) begin
          check("results_moved_without_valid", {high_ticks, period_ticks}, {prev_h, prev_p});
        end
      end
      prev_pwm = pwm_in;
      prev_mv  = meas_valid;
      prev_h   = high_ticks;
      prev_p   = period_ticks;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input int h, input int l, input int n);
    repeat (n) begin
      pwm_in = 1'b1;
      wait_clk(h);
      pwm_in = 1'b0;
      wait_clk(l);
    end
  endtask

  task automatic arm(input int d);
    div = '0;
    wait_clk(2);
    div = DIV_W'(d);
    wait_clk(3);
  endtask

  // n full periods whose widths are whole multiples of d: first rise arms, the rest report
  task automatic segment(input int d, input int h, input int l, input int n, input string tag);
    int p0;
    arm(d);
    exp_high = h / d;
    exp_per  = (h + l) / d;
    p0 = n_pulse;
    drive(h, l, n);
    wait_clk(LAT + 1);
    check({tag, "_pulses"}, n_pulse - p0, n - 1);
    check({tag, "_locked"}, locked, (n > 1) ? 1 : 0);
  endtask

  initial begin : main
    int p0;
    int d, a, b, n;

    wait_clk(2);
    check("rst_high", high_ticks, 0);
    check("rst_period", period_ticks, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_stalled", stalled, 0);
    check("rst_locked", locked, 0);
    reset = 1'b0;
    wait_clk(2);

    segment(1, 3, 5, 4, "d1_3_5");
    segment(1, 1, 1, 5, "min_1_1");
    segment(4, 40, 60, 3, "d4_40_100");

    p0 = n_pulse;
    div = '0;
    drive(40, 60, 2);
    wait_clk(LAT + 1);
    check("div0_pulses", n_pulse - p0, 0);
    check("div0_high_hold", high_ticks, 10);
    check("div0_period_hold", period_ticks, 25);
    check("div0_locked", locked, 0);

    segment(2, 60, 140, 3, "loopback");

    repeat (6) begin
      d = $urandom_range(1, 5);
      a = $urandom_range(1, 6);
      b = a + $urandom_range(1, 6);
      n = $urandom_range(2, 4);
      segment(d, a * d, (b - a) * d, n, "rand");
    end

    arm(1);
    exp_high = 3;
    exp_per  = 8;
    p0 = n_pulse;
    pwm_in = 1'b1;
    wait_clk(70000);
    check("stall_stalled", stalled, 1);
    check("stall_pulses", n_pulse - p0, 0);
    pwm_in = 1'b0;
    wait_clk(5);
    check("stall_sticky", stalled, 1);
    drive(3, 5, 3);
    wait_clk(LAT + 1);
    check("resume_pulses", n_pulse - p0, 2);
    check("resume_stalled", stalled, 0);
    check("resume_locked", locked, 1);

    arm(1);
    exp_high = 4;
    exp_per  = 8;
    p0 = n_pulse;
    drive(4, 4, 3);
    pwm_in = 1'b1;
    wait_clk(4);
    pwm_in = 1'b0;
    wait_clk(2);
    div = DIV_W'(2);
    wait_clk(2);
    check("rearm_locked", locked, 0);
    check("rearm_high_hold", high_ticks, 4);
    check("rearm_period_hold", period_ticks, 8);
    wait_clk(2);
    check("rearm_inflight_pulses", n_pulse - p0, 3);
    exp_high = 2;
    exp_per  = 4;
    p0 = n_pulse;
    drive(4, 4, 3);
    wait_clk(LAT + 1);
    check("rearm_d2_pulses", n_pulse - p0, 2);
    check("rearm_d2_locked", locked, 1);

    arm(1);
    exp_high = 3;
    exp_per  = 8;
    drive(3, 5, 2);
    pwm_in = 1'b1;
    wait_clk(LAT);
    reset = 1'b1;
    #1;
    check("async_rst_high", high_ticks, 0);
    check("async_rst_period", period_ticks, 0);
    check("async_rst_valid", meas_valid, 0);
    check("async_rst_stalled", stalled, 0);
    check("async_rst_locked", locked, 0);
    pwm_in = 1'b0;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(3);
    p0 = n_pulse;
    drive(3, 5, 3);
    wait_clk(LAT + 1);
    check("post_rst_pulses", n_pulse - p0, 2);
    check("post_rst_locked", locked, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Input-capture counterpart to the PWM generator. It measures the high time and the period of an external PWM signal, counted in prescaled ticks. Results go to register-file read slots, so firmware sees the same PWMH/PWMT/div semantics it writes to the generator. The block sits in the IO block next to the PWM driver, taking one data_in pin.

Parameters:
CNT_W, 16, width of the high/period counters and results
DIV_W, 8, width of the prescaler divide value
SYNC_STAGES, 2, synchroniser flops on pwm_in (minimum 2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
pwm_in  in  1  asynchronous PWM pin
div  in  DIV_W  prescaler; a tick occurs every div clocks; 0 disables the block
high_ticks  out  CNT_W  last completed high time, in ticks
period_ticks  out  CNT_W  last completed period (rise to rise), in ticks
meas_valid  out  1  one-cycle pulse when high_ticks/period_ticks update
stalled  out  1  period counter saturated without an edge; sticky until next meas_valid
locked  out  1  at least one measurement completed since reset or re-arm

Behaviour:
- Reset (async): all outputs 0; FSM IDLE; counters, prescaler, synchroniser and edge-history flops all 0.
- Sync and edge detect:
  - pwm_in passes through SYNC_STAGES flops; s is the last stage.
  - rise = s & ~s_d; fall = ~s & s_d (s_d is s delayed one clock).
- Prescaler: free-running presc_cnt.
  - If div==0: presc_cnt=0, no tick.
  - Else if presc_cnt >= div-1: tick=1 and presc_cnt<=0.
  - Else presc_cnt+1.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on rise -> HIGH, cnt_high<=tick, cnt_per<=tick. The first rise never produces meas_valid.
  - HIGH, tick without fall: cnt_high and cnt_per increment (saturating).
  - HIGH, fall: h_shadow<=cnt_high (the tick in this cycle is NOT added), cnt_per<=cnt_per+tick -> LOW.
  - LOW, tick without rise: cnt_per increments (saturating).
  - LOW, rise: period_ticks<=cnt_per, high_ticks<=h_shadow, meas_valid=1, locked=1, stalled=0; cnt_high<=tick, cnt_per<=tick -> HIGH.
- Saturation:
  - cnt_high saturates silently at all-ones.
  - When cnt_per reaches all-ones in HIGH or LOW: stalled<=1, FSM -> IDLE, no meas_valid, results hold.
- Re-arm: div==0, or div differing from its registered copy, forces IDLE and clears counters and locked. stalled and results hold.
- Latency: meas_valid is high in the cycle after clock edge number SYNC_STAGES, counting from edge 0, the first edge that samples pwm_in high.
- meas_valid is never high in two consecutive cycles. Results change only together with meas_valid.
- Minimum measurable: 1 clock high / 1 clock low, at div=1.
- Reset mid-measurement returns to IDLE; the next full cycle requires two rises.

Decomposition:
- Package pwm_capture_pkg holds the state_t enum (IDLE, HIGH, LOW) and the CNT_W/DIV_W defaults, shared with the register map.
- One sub-module, pwm_in_sync: the synchroniser plus the rise/fall detector. The prescaler and FSM stay in pwm_capture.

Test Plan:
- div=1; pwm_in high 3 clocks, low 5, repeated -> from the second rise, every period: meas_valid pulse, high_ticks=3, period_ticks=8, locked=1.
- div=4; high 40 clocks, period 100 clocks -> high_ticks=10, period_ticks=25. With div=0: no meas_valid, outputs hold.
- Loopback from the existing PWM generator with PWMH=30, PWMT=99, div=2 (60 clocks high, 200 clocks period); capture div=2 -> high_ticks=30, period_ticks=100 on every pulse.
- div=1; one rise then pwm_in stuck high for 70000 clocks -> stalled=1 at cnt_per=65535, FSM IDLE, no meas_valid. After the 3-high/5-low waveform resumes, the second rise gives valid 3/8 and stalled=0.
- Change div 1->2 mid-LOW -> locked=0, no pulse for the in-flight period. Results hold old values until the next full period, then report values at div=2.
- Assert reset during HIGH -> all outputs 0 immediately (async). After release, the first rise gives no meas_valid; the second rise gives correct values.
